// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth multiplier
package booth_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } digit_t;

    // Unsigned operands need one extra digit to cover the zero-extension bits
    function automatic int iter_count(input int width, input logic sgn);
        return sgn ? width / 2 : width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: maps a 3-bit Booth window to a {neg, two, zero} digit
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] bits,
    output digit_t     dig
);

    // Windows 100/101/110 are negative, 011/100 select 2M, 000/111 are zero
    always_comb begin
        dig.neg  = bits[2] & ~(bits[1] & bits[0]);
        dig.two  = (bits == 3'b011) | (bits == 3'b100);
        dig.zero = (bits == 3'b000) | (bits == 3'b111);
    end

endmodule

// File: rtl/booth_r4_mult.sv
// booth_r4_mult: radix-4 Booth multiplier, signed/unsigned, start/busy/done handshake
// Optional BOOTH_EARLY_TERM_EN: stop once all remaining digits are zero, report cycles_used
module booth_r4_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef BOOTH_EARLY_TERM_EN
    ,
    output logic [CNT_W-1:0]   cycles_used
`endif
);

    localparam int AW = 2 * WIDTH + 2;
    localparam int QW = WIDTH + 2;

    state_t           state, state_nx;
    logic [AW-1:0]    m, acc, addend, acc_nx;
    logic [QW-1:0]    q, q_nx;
    logic             q_m1;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             fin;
    digit_t           dig;

    booth_r4_recoder u_rec (
        .bits({q[1:0], q_m1}),
        .dig (dig)
    );

    // One Booth step: apply the digit, shift the multiplier, decide if this is the last step
    always_comb begin
        addend = dig.zero ? '0 : (dig.two ? m << 1 : m);
        acc_nx = dig.neg ? acc - addend : acc + addend;
        q_nx   = {{2{q[QW-1]}}, q[QW-1:2]};
        cnt_nx = cnt - CNT_W'(1);
        fin    = cnt_nx == '0;
`ifdef BOOTH_EARLY_TERM_EN
        fin    = fin | (&{q_nx, q[1]}) | ~|{q_nx, q[1]};
`endif
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx = state == IDLE ? (start ? CALC : IDLE) :
                   state == CALC ? (fin ? DONE : CALC) : IDLE;
        busy     = state != IDLE;
        done     = state == DONE;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Datapath: load on accept, iterate in CALC, capture product on the final step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && start) begin
            m    <= {{(AW - WIDTH){signed_mode & mcand[WIDTH-1]}}, mcand};
            q    <= {{2{signed_mode & mplier[WIDTH-1]}}, mplier};
            q_m1 <= 1'b0;
            acc  <= '0;
            cnt  <= CNT_W'(iter_count(WIDTH, signed_mode));
        end else if (state == CALC) begin
            acc  <= acc_nx;
            m    <= m << 2;
            q    <= q_nx;
            q_m1 <= q[1];
            cnt  <= cnt_nx;
            if (fin) product <= acc_nx[2*WIDTH-1:0];
        end
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic [CNT_W-1:0] used;

    // Count CALC cycles; the value stays put through DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        used <= '0;
        else if (state == IDLE && start) used <= '0;
        else if (state == CALC)          used <= used + CNT_W'(1);
    end

    assign cycles_used = used;
`endif

endmodule

// File: doc/booth_r4_mult.md
Name: booth_r4_mult

Overview:
- Parametrised radix-4 (modified) Booth multiplier.
- Successor to the 16-bit radix-2 controller/datapath multiplier; single module with an internal FSM plus datapath.
- Operands are loaded in parallel in one cycle. Signed and unsigned modes are selectable per operation.
- Two multiplier bits are retired per cycle. A start/busy/done handshake serves the surrounding arithmetic unit.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH/2+2), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned. Captured with start.
- mcand  input  WIDTH  multiplicand; captured with start.
- mplier  input  WIDTH  multiplier; captured with start.
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse; product is valid in this cycle.
- product  output  2*WIDTH  result register; holds its value until the next accepted start.

Behaviour:
- Reset (rst low, async):
  - State = IDLE; busy = 0; done = 0; product = 0.
  - All internal registers cleared.
  - Reset mid-operation aborts the operation with no partial result retained.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at a clock edge:
  - Multiplicand is sign-extended (signed mode) or zero-extended (unsigned) into a 2*WIDTH+2 bit register M.
  - Multiplier is extended by 2 bits the same way into register Q, with guard bit q_m1 = 0.
  - Accumulator is cleared; counter N = WIDTH/2 (signed) or WIDTH/2+1 (unsigned).
  - State goes to CALC.
- CALC, each edge:
  - Digit d from {Q[1],Q[0],q_m1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - acc += d (2*WIDTH+2 bit arithmetic, wrap allowed).
  - M <<= 2; q_m1 = Q[1]; Q arithmetic-shifted right by 2; counter decrements.
  - When the counter reaches 0 after the update, state goes to DONE.
- DONE (one cycle):
  - done = 1; product = acc[2*WIDTH-1:0], registered on entry to DONE so it is visible in that cycle.
  - Next edge goes to IDLE.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+N. Signed WIDTH=16: 8 CALC cycles; unsigned: 9.
- start while busy is ignored; no queueing. start held high through DONE is re-accepted only in IDLE.
- signed_mode, mcand and mplier are don't-care outside the accept edge.
- Results:
  - Unsigned: full 2*WIDTH-bit product, exact.
  - Signed: two's-complement exact, including (-2^(W-1))^2 = 2^(2W-2).

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined: in CALC, before processing a digit, if all remaining bits of Q and q_m1 are equal (all remaining digits zero), the FSM goes directly to DONE and skips the remaining cycles.
  - Product is identical to the full run.
  - Minimum latency is 1 CALC cycle (multiplier 0 or -1 with q_m1 match).
  - Adds output cycles_used[CNT_W-1:0], valid with done.
- Undefined: fixed latency of N cycles; the cycles_used port is absent.

Decomposition:
- Package booth_pkg:
  - State enum (IDLE/CALC/DONE).
  - Booth digit encoding typedef {neg, two, zero}.
  - Function computing the iteration count from WIDTH and mode.
- Sub-module booth_r4_recoder (combinational): 3 input bits -> {neg, two, zero}. It is instantiated once; a separate module lets the recoding be verified exhaustively.

Test Plan:
- WIDTH=16, signed: 3*5 -> product 15; 7*6 -> 42; 12*(-81) -> -972 (0xFFFFFC34). done exactly 8 cycles after the accept edge; busy high throughout.
- Unsigned: 0xFFFF*0xFFFF -> 0xFFFE0001. Signed: 0x8000*0x8000 -> 0x40000000; 0x8000*0x7FFF -> 0xC0008000.
- Handshake: start re-pulsed with new operands (9*9) during CALC -> ignored; first product is unaffected; a new start in IDLE then yields 81.
- Reset: rst driven low at CALC cycle 4 -> busy=0, done=0, product=0 immediately. After release, a fresh 7*6 completes with 42.
- Recoder: all 8 input codes checked against the digit table; 200 random signed/unsigned pairs compared with a reference product.
- With BOOTH_EARLY_TERM_EN: 1234*0 -> 0, cycles_used=1; 5*3 -> 15 in 2 cycles; (-1)*(-1) signed -> 1 with reduced cycles.
